// File: rtl/mac_pkg.sv
// Shared MAC definitions: operand modes, stage-1 control struct and the
// width-generic saturating/wrapping accumulate used by the MAC datapaths.
`ifndef MAC_PKG_SV
`define MAC_PKG_SV

// Elaboration-time guard placed inside any MAC module body.
`define MAC_WIDTH_CHECK(DW, AW) \
  if ((DW) < 2 || (AW) < 2*(DW) || (AW) > mac_pkg::MAC_MAX_W) begin : g_bad_widths \
    $error("mac: need DATA_W >= 2 and 2*DATA_W <= ACC_W <= MAC_MAX_W"); \
  end

package mac_pkg;

  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;
  localparam int   MAC_MAX_W     = 64;

  typedef struct packed {
    logic first;
    logic last;
    logic mode;
  } mac_ctl_t;

  // Adds two w-bit values held in MAC_MAX_W containers; returns {ovf, result}.
  function automatic logic [MAC_MAX_W:0] sat_add(
    input logic [MAC_MAX_W-1:0] base,
    input logic [MAC_MAX_W-1:0] addend,
    input int                   w,
    input logic                 is_signed,
    input logic                 sat
  );
    logic [MAC_MAX_W:0] one, mask, top, sum, res;
    logic               sb, sa, ss, ovf;
    one  = {{MAC_MAX_W{1'b0}}, 1'b1};
    mask = (one << w) - one;
    top  = one << (w - 1);
    sum  = ({1'b0, base} & mask) + ({1'b0, addend} & mask);
    sb   = |({1'b0, base} & top);
    sa   = |({1'b0, addend} & top);
    ss   = |(sum & top);
    ovf  = is_signed ? ((sb == sa) && (ss != sb)) : |(sum & (mask + one));
    res  = sum & mask;
    if (sat && ovf) begin
      if (!is_signed) res = mask;
      else if (sb)    res = top;
      else            res = top - one;
    end
    return {ovf, res[MAC_MAX_W-1:0]};
  endfunction

endpackage

`endif

// File: rtl/mac_mul_stage.sv
// DATA_W x DATA_W multiplier with a registered, enable-gated product.
module mac_mul_stage
  import mac_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  mode,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic [2*DATA_W-1:0]   prod_q
);

  localparam int PW = 2*DATA_W;

  logic [PW-1:0] a_x, b_x, prod_d;

  // Extending both operands to full width makes the low PW bits exact either way.
  always_comb begin
    if (mode == MODE_SIGNED) begin
      a_x = PW'($signed(a));
      b_x = PW'($signed(b));
    end else begin
      a_x = PW'(a);
      b_x = PW'(b);
    end
    prod_d = en ? a_x * b_x : prod_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prod_q <= '0;
    else        prod_q <= prod_d;
  end

endmodule

// File: rtl/mac_acc_pipe.sv
// Two-stage multiply-accumulate over first/last delimited beat groups, with
// sticky overflow per group and optional saturation.
module mac_acc_pipe
  import mac_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int SAT    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [ACC_W-1:0]  in_c,
  input  logic              in_first,
  input  logic              in_last,
  input  logic              in_signed,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_ovf
);

  `MAC_WIDTH_CHECK(DATA_W, ACC_W)

  localparam int STAGES = 2;
  localparam int PW     = 2*DATA_W;

  logic              advance, accept, upd, eff_mode;
  logic [STAGES:0]   vld_pipe;
  logic [PW-1:0]     prod;
  mac_ctl_t          s1_ctl_q, s1_ctl_d;
  logic [ACC_W-1:0]  s1_c_q, s1_c_d, acc_q, acc_d, out_data_q, out_data_d;
  logic [ACC_W-1:0]  base, addend, new_acc;
  logic              s1_vld_q, s1_vld_d, mode_q, mode_d, sticky_q, sticky_d;
  logic              out_valid_q, out_valid_d, out_ovf_q, out_ovf_d, new_sticky;
  logic [MAC_MAX_W:0] sum_r;

  // Whole pipe stalls only when a result is parked at the output.
  assign advance  = ~out_valid_q | out_ready;
  assign in_ready = advance;
  assign accept   = in_valid & advance;
  assign eff_mode = in_first ? in_signed : mode_q;
  assign vld_pipe = {out_valid_q, s1_vld_q, accept};
  assign upd      = advance & vld_pipe[1];

  mac_mul_stage #(.DATA_W(DATA_W)) u_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (accept),
    .mode   (eff_mode),
    .a      (in_a),
    .b      (in_b),
    .prod_q (prod)
  );

  always_comb begin
    s1_vld_d = advance ? accept : s1_vld_q;
    s1_ctl_d = s1_ctl_q;
    s1_c_d   = s1_c_q;
    mode_d   = mode_q;
    if (accept) begin
      s1_ctl_d = '{first: in_first, last: in_last, mode: eff_mode};
      s1_c_d   = in_c;
      mode_d   = eff_mode;
    end
  end

  always_comb begin
    base = s1_ctl_q.first ? s1_c_q : acc_q;
    if (s1_ctl_q.mode == MODE_SIGNED) addend = ACC_W'($signed(prod));
    else                              addend = ACC_W'(prod);
    sum_r = sat_add(MAC_MAX_W'(base), MAC_MAX_W'(addend), ACC_W,
                    s1_ctl_q.mode == MODE_SIGNED, SAT != 0);
    new_acc    = sum_r[ACC_W-1:0];
    new_sticky = (~s1_ctl_q.first & sticky_q) | sum_r[MAC_MAX_W];

    acc_d       = acc_q;
    sticky_d    = sticky_q;
    out_valid_d = out_valid_q & ~out_ready;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    if (upd) begin
      acc_d    = new_acc;
      sticky_d = new_sticky;
      // A landing last overrides the drain, so back-to-back results never bubble.
      if (s1_ctl_q.last) begin
        out_valid_d = 1'b1;
        out_data_d  = new_acc;
        out_ovf_d   = new_sticky;
      end
    end
  end

  if (ACC_W < MAC_MAX_W) begin : g_hi
    logic unused_sum_hi;
    assign unused_sum_hi = ^sum_r[MAC_MAX_W-1:ACC_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q    <= 1'b0;
      s1_ctl_q    <= '0;
      s1_c_q      <= '0;
      mode_q      <= MODE_UNSIGNED;
      acc_q       <= '0;
      sticky_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      s1_vld_q    <= s1_vld_d;
      s1_ctl_q    <= s1_ctl_d;
      s1_c_q      <= s1_c_d;
      mode_q      <= mode_d;
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_mac_acc_pipe.sv
// Scoreboard bench: a 24-bit wrapping engine plus a saturating/wrapping
// 16-bit pair; stimulus queues expected results, one monitor checks them.
module tb_mac_acc_pipe;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        iv = 1'b0, en24 = 1'b0, en16 = 1'b0, rdy = 1'b1;
  logic [7:0]  a = '0, b = '0;
  logic [23:0] c = '0;
  logic        first = 1'b0, last = 1'b0, sgn = 1'b0;

  logic        m_ir, m_ov, m_of, s_ir, s_ov, s_of, w_ir, w_ov, w_of, hs_rdy;
  logic [23:0] m_od;
  logic [15:0] s_od, w_od;

  typedef struct {
    logic [23:0] d;
    logic        o;
    int          cyc;
  } exp_t;

  exp_t q_m[$], q_s[$], q_w[$];
  exp_t e;
  int   n_pass = 0, n_tot = 0, cyc = 0, hs_to = 0;
  logic rst_chk = 1'b0, bp_chk = 1'b0, done = 1'b0;
  logic [23:0] bp_data = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign hs_rdy = en24 ? m_ir : (s_ir & w_ir);

  mac_acc_pipe #(.DATA_W(8), .ACC_W(24), .SAT(0)) dut_m (
    .clk(clk), .rst_n(rst_n), .in_valid(iv & en24), .in_ready(m_ir),
    .in_a(a), .in_b(b), .in_c(c), .in_first(first), .in_last(last),
    .in_signed(sgn), .out_valid(m_ov), .out_ready(rdy), .out_data(m_od),
    .out_ovf(m_of));

  mac_acc_pipe #(.DATA_W(8), .ACC_W(16), .SAT(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(iv & en16), .in_ready(s_ir),
    .in_a(a), .in_b(b), .in_c(c[15:0]), .in_first(first), .in_last(last),
    .in_signed(sgn), .out_valid(s_ov), .out_ready(rdy), .out_data(s_od),
    .out_ovf(s_of));

  mac_acc_pipe #(.DATA_W(8), .ACC_W(16), .SAT(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(iv & en16), .in_ready(w_ir),
    .in_a(a), .in_b(b), .in_c(c[15:0]), .in_first(first), .in_last(last),
    .in_signed(sgn), .out_valid(w_ov), .out_ready(rdy), .out_data(w_od),
    .out_ovf(w_of));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic cmp(input string tag, input exp_t x, input logic [23:0] d, input logic o);
    chk({tag, "_data"}, 32'(d), 32'(x.d));
    chk({tag, "_ovf"}, 32'(o), 32'(x.o));
    if (x.cyc >= 0) chk({tag, "_latency_cycle"}, cyc, x.cyc);
  endtask

  // Monitor: the only process that compares or counts.
  always @(negedge clk) begin
    if (rst_chk) begin
      chk("rst_out_valid", 32'(m_ov), 0);
      chk("rst_out_data", 32'(m_od), 0);
      chk("rst_out_ovf", 32'(m_of), 0);
      chk("rst_in_ready", 32'(m_ir), 1);
    end
    if (bp_chk) begin
      chk("bp_in_ready", 32'(m_ir), 0);
      chk("bp_out_valid", 32'(m_ov), 1);
      chk("bp_out_data", 32'(m_od), 32'(bp_data));
    end
    if (m_ov && rdy) begin
      if (q_m.size() == 0) begin
        n_tot++;
        $display("FAIL m_unexpected_result: got 0x%0h, expected no result", m_od);
      end else begin
        e = q_m.pop_front();
        cmp("m", e, m_od, m_of);
      end
    end
    if (s_ov && rdy) begin
      if (q_s.size() == 0) begin
        n_tot++;
        $display("FAIL s_unexpected_result: got 0x%0h, expected no result", s_od);
      end else begin
        e = q_s.pop_front();
        cmp("s", e, 24'(s_od), s_of);
      end
    end
    if (w_ov && rdy) begin
      if (q_w.size() == 0) begin
        n_tot++;
        $display("FAIL w_unexpected_result: got 0x%0h, expected no result", w_od);
      end else begin
        e = q_w.pop_front();
        cmp("w", e, 24'(w_od), w_of);
      end
    end
    if (done) begin
      chk("m_results_missing", q_m.size(), 0);
      chk("s_results_missing", q_s.size(), 0);
      chk("w_results_missing", q_w.size(), 0);
      chk("handshake_timeouts", hs_to, 0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
    end
  end

  task automatic beat(input logic [7:0] ta, input logic [7:0] tb_, input logic [23:0] tc,
                      input logic tf, input logic tl, input logic ts);
    bit ok = 1'b0;
    a = ta; b = tb_; c = tc; first = tf; last = tl; sgn = ts; iv = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = hs_rdy;
      @(posedge clk); #1;
    end
    if (!ok) hs_to++;
    iv = 1'b0;
  endtask

  task automatic push_m(input logic [23:0] d, input logic o, input int cy);
    q_m.push_back('{d: d, o: o, cyc: cy});
  endtask

  task automatic push_16(input logic [15:0] ds, input logic [15:0] dw, input logic o, input int cy);
    q_s.push_back('{d: 24'(ds), o: o, cyc: cy});
    q_w.push_back('{d: 24'(dw), o: o, cyc: cy});
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && (q_m.size() + q_s.size() + q_w.size()) != 0; k++)
      @(posedge clk);
    idle(2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_chk = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    rst_chk = 1'b0;
    en24 = 1'b1;

    // Single-beat unsigned max product, latency T+2
    beat(8'd255, 8'd255, 24'd0, 1, 1, 0); push_m(24'h00FE01, 0, cyc + 1);
    drain();

    // Back-to-back dot product seeded with 100
    beat(8'd1, 8'd5, 24'd100, 1, 0, 0);
    beat(8'd2, 8'd6, 24'd0, 0, 0, 0);
    beat(8'd3, 8'd7, 24'd0, 0, 0, 0);
    beat(8'd4, 8'd8, 24'd0, 0, 1, 0); push_m(24'd170, 0, cyc + 1);
    drain();

    // Signed groups, then continuation without first keeps signed mode
    beat(8'hFD, 8'd7, 24'd0, 1, 1, 1);          push_m(24'hFFFFEB, 0, cyc + 1);
    beat(8'h80, 8'h80, 24'hFFFFFF, 1, 1, 1);    push_m(24'h003FFF, 0, cyc + 1);
    beat(8'hFF, 8'd1, 24'd0, 0, 1, 0);          push_m(24'h003FFE, 0, cyc + 1);
    // first mid-group discards the open partial
    beat(8'd10, 8'd10, 24'd0, 1, 0, 0);
    beat(8'd2, 8'd2, 24'd1, 1, 1, 0);           push_m(24'd5, 0, cyc + 1);
    // bubbles inside a group
    beat(8'd1, 8'd1, 24'd0, 1, 0, 0);
    idle(3);
    beat(8'd2, 8'd2, 24'd0, 0, 1, 0);           push_m(24'd5, 0, cyc + 1);
    drain();

    // Backpressure: two single-beat groups held for 5 cycles
    beat(8'd3, 8'd4, 24'd0, 1, 1, 0);           push_m(24'd12, 0, -1);
    rdy = 1'b0;
    beat(8'd5, 8'd6, 24'd0, 1, 1, 0);           push_m(24'd30, 0, -1);
    bp_data = 24'd12;
    bp_chk = 1'b1;
    idle(5);
    bp_chk = 1'b0;
    rdy = 1'b1;
    drain();

    // Asynchronous reset after 2 of 4 beats
    beat(8'd1, 8'd1, 24'd0, 1, 0, 0);
    beat(8'd1, 8'd1, 24'd0, 0, 0, 0);
    rst_n = 1'b0;
    rst_chk = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    rst_chk = 1'b0;
    beat(8'd2, 8'd3, 24'd0, 1, 1, 0);           push_m(24'd6, 0, cyc + 1);
    drain();

    // 16-bit pair: saturating vs wrapping
    en24 = 1'b0;
    en16 = 1'b1;
    beat(8'd255, 8'd255, 24'h00FFF0, 1, 1, 0);  push_16(16'hFFFF, 16'hFDF1, 1, cyc + 1);
    beat(8'd1, 8'd1, 24'd0, 1, 1, 0);           push_16(16'h0001, 16'h0001, 0, cyc + 1);
    beat(8'h80, 8'h80, 24'h007FFF, 1, 1, 1);    push_16(16'h7FFF, 16'hBFFF, 1, cyc + 1);
    beat(8'h80, 8'h7F, 24'h008000, 1, 1, 1);    push_16(16'h8000, 16'h4080, 1, cyc + 1);
    // overflow on beat 0 must stick through a clean beat 1
    beat(8'd255, 8'd255, 24'h00FFF0, 1, 0, 0);
    beat(8'd0, 8'd0, 24'd0, 0, 1, 0);           push_16(16'hFFFF, 16'hFDF1, 1, cyc + 1);
    drain();

    done = 1'b1;
  end

endmodule

// File: doc/mac_acc_pipe.md
Name: mac_acc_pipe

Overview:
Parametrised, pipelined multiply-accumulate engine for the AI-chip datapath. It is the sequential successor to the combinational fixed-width MAC. It accepts a stream of (a, b) operand beats under valid/ready flow control and accumulates a*b onto a seed value c across a group of beats delimited by first/last flags. Each group emits one result with an overflow flag. It supports signed or unsigned operands and optional saturation.

Parameters:
DATA_W, 8, operand width of a and b (>=2)
ACC_W, 24, accumulator/result width; elaboration error if ACC_W < 2*DATA_W
SAT, 0, 1 = saturate accumulator on overflow, 0 = wrap modulo 2^ACC_W

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset; asynchronous assert, active-low
in_valid  in  1  input beat valid
in_ready  out  1  engine can accept beat
in_a  in  DATA_W  multiplicand
in_b  in  DATA_W  multiplier
in_c  in  ACC_W  accumulator seed, used only on first beat
in_first  in  1  beat starts a group
in_last  in  1  beat ends a group (first&last = single-beat group)
in_signed  in  1  1 = two's-complement operands/accumulator; sampled on first beat only
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  ACC_W  accumulated result
out_ovf  out  1  overflow occurred at any beat of this group

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_ovf=0, all stage valids=0, acc=0, ovf sticky=0, mode=unsigned. in_ready=1 in the first cycle after release.
- Flow control: advance = ~out_valid | out_ready; in_ready = advance (combinational). When advance=0 every pipeline register holds.
- Accepted beat: in_valid & in_ready.
- Stage 1 (on accept): register the 2*DATA_W product, computed signed or unsigned per the effective mode, plus first, last and c. The effective mode is in_signed on a first beat, else the latched group mode.
- Stage 2 (when advance & s1_valid):
  - base = s1_first ? s1_c : acc
  - sum = base + ext(product), computed in ACC_W+1 bits; ext is sign- or zero-extension per mode.
  - Unsigned overflow = carry out of bit ACC_W-1. Signed overflow = operands share a sign and the sum sign differs.
  - SAT=1: on overflow, clamp. Unsigned clamps to 2^ACC_W-1. Signed clamps to +2^(ACC_W-1)-1 or -2^(ACC_W-1) by the sign of the operand. SAT=0: wrap.
  - acc <= clamped/wrapped sum. ovf_sticky <= (s1_first ? 0 : ovf_sticky) | overflow.
- Output: when a stage-2 update carries last, out_data <= new acc and out_ovf <= new sticky in the same edge, and out_valid <= 1. out_valid clears on out_valid & out_ready unless a new last lands in the same edge; in that case it stays 1 with the new data, back-to-back.
- Latency: the last beat accepted in cycle T gives out_valid=1 in cycle T+2. Throughput is 1 beat/cycle with out_ready held high.
- out_data/out_ovf are stable while out_valid & ~out_ready.
- Beat without first after a completed group: continues from the current acc (no implicit clear); mode unchanged.
- in_first on a beat while a group is open: discards the old partial acc and starts a new group.
- Bubbles (in_valid low) mid-group: acc holds; no effect on result.
- Reset mid-group or with out_valid high: everything is discarded and no result is emitted.

Decomposition:
- Shared package mac_pkg holds:
  - mode constants MODE_UNSIGNED=0, MODE_SIGNED=1
  - function sat_add(base, addend, signed, sat) returning {ovf, result}, reused by future array MACs
  - width-check macro/assertion for ACC_W >= 2*DATA_W
- One natural sub-module, mac_mul_stage: the DATA_W x DATA_W signed/unsigned multiplier with registered output and enable.

Test Plan:
- Unsigned, DATA_W=8/ACC_W=24, one beat a=255 b=255 c=0 first&last -> out_data=0x00FE01 at T+2, out_ovf=0.
- Dot product, 4 beats a={1,2,3,4} b={5,6,7,8} c=100, first on beat0, last on beat3, back-to-back -> out_data=170, exactly one out_valid pulse.
- Signed: a=-3 b=7 c=0 -> out_data=0xFFFFEB; next group a=-128 b=-128 c=-1 -> 0x003FFF.
- ACC_W=16 unsigned, c=0xFFF0, a=b=255:
  - SAT=1 -> out_data=0xFFFF, out_ovf=1
  - SAT=0 -> out_data=0xFDF1, out_ovf=1
  - following clean group -> out_ovf=0
- Backpressure: two single-beat groups (3*4, 5*6); hold out_ready=0 for 5 cycles after the first out_valid -> in_ready=0 throughout, out_data=12 stable, then 12 and 30 delivered in order with no loss.
- Reset pulse asserted asynchronously mid-group after 2 of 4 beats -> outputs 0 immediately; a fresh group a=2 b=3 c=0 yields 6.
